// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of {instr, pc}
// with valid/ready on both sides and a flush that drops all wrong-path entries.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]        in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_instr,
  output logic [DATA_W-1:0]        out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; flush suppresses both transfers that cycle. in_ready depends
  // only on count, so a pop never opens a slot for a push in the same cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    out_instr = NOP;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = instr_mem[rd_ptr];
      out_pc    = pc_mem[rd_ptr];
    end
  end

  // Storage is not reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int W      = 2 * DATA_W;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc;
  logic              out_ready;
  logic              flush;
  logic [2:0]        count;

  logic [W-1:0] exp_q[$];
  int n_compared;
  int n_mismatched;

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [W-1:0] head;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : {NOP, {DATA_W{1'b0}}};
    check_eq("count", 64'(count), 64'(sz));
    check_eq("out_valid", 64'(out_valid), 64'(sz != 0));
    check_eq("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    check_eq("out_instr", 64'(out_instr), 64'(head[W-1:DATA_W]));
    check_eq("out_pc", 64'(out_pc), 64'(head[DATA_W-1:0]));
  endtask

  // Check current outputs, advance one clock, update the model. Callers set
  // inputs while time sits 1 unit after a rising edge.
  task automatic cycle();
    logic do_push, do_pop;
    check_outputs();
    do_push = rst && in_valid && (exp_q.size() < DEPTH) && !flush;
    do_pop  = rst && out_ready && (exp_q.size() != 0) && !flush;
    @(posedge clk);
    if (!rst || flush) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_instr, in_pc});
    end
    #1;
  endtask

  // driver tasks
  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic offer(input logic [DATA_W-1:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = $urandom;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    idle();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst      = 1'b0;
    in_instr = '0;
    in_pc    = '0;
    idle();

    // reset held with toggling inputs
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_pc     = $urandom;
      in_instr  = $urandom;
      cycle();
    end
    check_eq("rst_out_instr", 64'(out_instr), 64'(NOP));
    rst = 1'b1;
    idle();

    // fill then drain
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'(i * 4));
      cycle();
    end
    check_eq("fill_count", 64'(count), 64'd4);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    offer(32'h10);
    cycle();
    check_eq("held_count", 64'(count), 64'd4);
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_pc", 64'(out_pc), 64'(i * 4));
      cycle();
    end
    check_eq("drain_empty", 64'(out_valid), 64'd0);
    idle();

    // streaming across pointer wrap
    offer(32'h100);
    cycle();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      check_eq("stream_pc", 64'(out_pc), 64'(32'h100 + (i - 1) * 4));
      offer(32'(32'h100 + i * 4));
      cycle();
      check_eq("stream_count", 64'(count), 64'd1);
    end
    drain();

    // full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'(32'h200 + i * 4));
      cycle();
    end
    offer(32'h210);
    out_ready = 1'b1;
    cycle();
    check_eq("full_pop_count", 64'(count), 64'd3);
    check_eq("full_pop_in_ready", 64'(in_ready), 64'd1);
    check_eq("full_pop_head", 64'(out_pc), 64'h204);
    drain();

    // flush priority over push and pop
    offer(32'h300); cycle();
    offer(32'h304); cycle();
    offer(32'h308);
    out_ready = 1'b1;
    flush     = 1'b1;
    cycle();
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    idle();
    offer(32'h40);
    cycle();
    idle();
    check_eq("post_flush_head", 64'(out_pc), 64'h40);
    check_eq("post_flush_count", 64'(count), 64'd1);
    drain();

    // pop on empty
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("empty_pop_count", 64'(count), 64'd0);
    offer(32'h500);
    out_ready = 1'b0;
    cycle();
    idle();
    check_eq("empty_pop_ptr", 64'(out_pc), 64'h500);
    drain();

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      offer(32'(32'h600 + i * 4));
      cycle();
    end
    idle();
    check_eq("pre_reset_count", 64'(count), 64'd3);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check_eq("async_rst_count", 64'(count), 64'd0);
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    cycle();
    rst = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      cycle();
    end
    idle();
    drain();
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
